// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the five-stage MIPS core sequencing logic:
// stall sequencer states, hazard stall-need encoding and register-zero/nop constants.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stall_state_t;

    typedef enum logic [1:0] {
        NEED_NONE = 2'd0,
        NEED_ONE  = 2'd1,
        NEED_TWO  = 2'd2
    } stall_need_t;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // $zero is never a real producer, so writes to it can never create a hazard.
    function automatic logic src_hit(input logic [4:0] addr,
                                     input logic [4:0] wa,
                                     input logic       uses);
        return uses && (addr == wa) && (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Combinational hazard detector: how many bubbles the ID instruction needs
// before its operands can be forwarded or compared in ID.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0]  i_ID_RSAddr,
    input  logic [4:0]  i_ID_RTAddr,
    input  logic        i_ID_UsesRS,
    input  logic        i_ID_UsesRT,
    input  logic        i_ID_IsBranch,
    input  logic        i_EX_RegWrite,
    input  logic        i_EX_MemRead,
    input  logic [4:0]  i_EX_WriteAddr,
    input  logic        i_MEM_MemRead,
    input  logic [4:0]  i_MEM_WriteAddr,
    output stall_need_t need
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = src_hit(i_ID_RSAddr, i_EX_WriteAddr, i_ID_UsesRS)
                   | src_hit(i_ID_RTAddr, i_EX_WriteAddr, i_ID_UsesRT);
    assign mem_hit = src_hit(i_ID_RSAddr, i_MEM_WriteAddr, i_ID_UsesRS)
                   | src_hit(i_ID_RTAddr, i_MEM_WriteAddr, i_ID_UsesRT);

    // Branches resolve in ID, so they wait for values that ALU-users could forward.
    always_comb begin
        need = NEED_NONE;
        if (i_EX_MemRead && ex_hit) begin
            need = i_ID_IsBranch ? NEED_TWO : NEED_ONE;
        end else if (i_EX_RegWrite && ex_hit && i_ID_IsBranch) begin
            need = NEED_ONE;
        end else if (i_MEM_MemRead && mem_hit && i_ID_IsBranch) begin
            need = NEED_ONE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall sequencer, redirect flush, memory freeze,
// freeze watchdog and saturating stall/flush statistics.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [4:0]       i_ID_RSAddr,
    input  logic [4:0]       i_ID_RTAddr,
    input  logic             i_ID_UsesRS,
    input  logic             i_ID_UsesRT,
    input  logic             i_ID_IsBranch,
    input  logic             i_IF_PCSrc,
    input  logic             i_EX_RegWrite,
    input  logic             i_EX_MemRead,
    input  logic [4:0]       i_EX_WriteAddr,
    input  logic             i_MEM_MemRead,
    input  logic [4:0]       i_MEM_WriteAddr,
    input  logic             i_MEM_Access,
    input  logic             i_MEM_Ready,
    output logic             o_IF_PCWrite,
    output logic             o_ID_IFIDWrite,
    output logic             o_ID_IFIDFlush,
    output logic             o_ID_BranchEn,
    output logic             o_EX_Bubble,
    output logic             o_Freeze,
    output logic             o_MemTimeout,
    output logic [CNT_W-1:0] o_StallCount,
    output logic [CNT_W-1:0] o_FlushCount
);

    localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

    stall_state_t     state;
    stall_state_t     state_next;
    logic             cnt;
    logic             cnt_next;
    stall_need_t      need;
    logic             freeze;
    logic             stall;
    logic             go;
    logic [15:0]      fcnt;
    logic [15:0]      fcnt_inc;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    hazard_detect u_detect (
        .i_ID_RSAddr     (i_ID_RSAddr),
        .i_ID_RTAddr     (i_ID_RTAddr),
        .i_ID_UsesRS     (i_ID_UsesRS),
        .i_ID_UsesRT     (i_ID_UsesRT),
        .i_ID_IsBranch   (i_ID_IsBranch),
        .i_EX_RegWrite   (i_EX_RegWrite),
        .i_EX_MemRead    (i_EX_MemRead),
        .i_EX_WriteAddr  (i_EX_WriteAddr),
        .i_MEM_MemRead   (i_MEM_MemRead),
        .i_MEM_WriteAddr (i_MEM_WriteAddr),
        .need            (need)
    );

    assign freeze = i_MEM_Access & ~i_MEM_Ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= RUN;
            cnt   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A freeze holds the sequencer where it is, so bubbles resume after the freeze.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RUN: begin
                if (!freeze && need == NEED_TWO) begin
                    state_next = STALL;
                    cnt_next   = 1'b0;
                end
            end
            STALL: begin
                if (!freeze && cnt == 1'b0) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = 1'b0;
            end
        endcase
    end

    always_comb begin
        stall = 1'b0;
        case (state)
            RUN:     stall = (need != NEED_NONE);
            STALL:   stall = 1'b1;
            default: stall = 1'b0;
        endcase
        go             = ~(stall | freeze);
        o_Freeze       = freeze;
        o_IF_PCWrite   = go;
        o_ID_IFIDWrite = go;
        o_ID_BranchEn  = go;
        o_EX_Bubble    = stall & ~freeze;
        o_ID_IFIDFlush = i_IF_PCSrc & go;
    end

    assign fcnt_inc = (fcnt == 16'hFFFF) ? fcnt : fcnt + 16'd1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fcnt      <= 16'd0;
            timeout_q <= 1'b0;
        end else if (freeze) begin
            fcnt <= fcnt_inc;
            if (fcnt_inc >= TIMEOUT_L) begin
                timeout_q <= 1'b1;
            end
        end else begin
            fcnt <= 16'd0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (o_EX_Bubble && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (o_ID_IFIDFlush && flush_cnt != {CNT_W{1'b1}}) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign o_MemTimeout = timeout_q;
    assign o_StallCount = stall_cnt;
    assign o_FlushCount = flush_cnt;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core. Detects load-use and branch-operand hazards against the instruction in ID, stalls IF/ID and injects ID/EX bubbles with a small stall sequencer, flushes IF/ID on taken branches and jumps resolved in ID, and freezes the whole pipeline while the data memory has not yet acknowledged an access. It also keeps saturating stall/flush statistics and a sticky memory-timeout flag.

## Interface
- CNT_W, 16, width of the statistics counters
- TIMEOUT, 255, freeze cycles after which o_MemTimeout sets (1..2^16-1)
- clk  in  1  clock, all state on rising edge
- nrst  in  1  reset, asynchronous, active-low
- i_ID_RSAddr / i_ID_RTAddr  in  5 each  source registers of the ID instruction
- i_ID_UsesRS / i_ID_UsesRT  in  1 each  ID instruction reads that source
- i_ID_IsBranch  in  1  ID instruction is beq/bne/jr (operands compared/used in ID)
- i_IF_PCSrc  in  1  ID redirect request (taken branch/jump)
- i_EX_RegWrite, i_EX_MemRead  in  1 each  EX-stage control
- i_EX_WriteAddr  in  5  EX destination register (after RegDst/link select)
- i_MEM_MemRead  in  1  MEM-stage instruction is a load
- i_MEM_WriteAddr  in  5  MEM destination register
- i_MEM_Access  in  1  MEM stage holds a load/store (level, held while frozen)
- i_MEM_Ready  in  1  data memory completes the access this cycle
- o_IF_PCWrite  out  1  PC may update
- o_ID_IFIDWrite  out  1  IF/ID may load
- o_ID_IFIDFlush  out  1  IF/ID loads a nop
- o_ID_BranchEn  out  1  ID may act on i_IF_PCSrc
- o_EX_Bubble  out  1  ID/EX loads zero control
- o_Freeze  out  1  ID/EX, EX/MEM, MEM/WB hold
- o_MemTimeout  out  1  sticky watchdog flag
- o_StallCount / o_FlushCount  out  CNT_W each  saturating statistics

## Operation
- Match terms ignore destination 0. srcHit(addr,wa) = addr==wa && addr!=0 && uses.
- Required stall count N (RUN only): EX load hits used source: N=2 if i_ID_IsBranch else 1; else EX non-load RegWrite hits and IsBranch: N=1; else MEM load hits and IsBranch: N=1; else 0.
- freeze = i_MEM_Access & ~i_MEM_Ready; highest priority.
- FSM states RUN, STALL; 1-bit counter cnt.
  - RUN, freeze: hold state, stall=0.
  - RUN, N>0, no freeze: stall=1; N=2 -> STALL, cnt=0; N=1 -> stay RUN.
  - STALL, no freeze: stall=1, -> RUN. STALL, freeze: stay, stall outputs suppressed.
- Outputs (combinational from state/inputs): o_Freeze=freeze; o_IF_PCWrite=o_ID_IFIDWrite=~(stall|freeze); o_EX_Bubble=stall&~freeze; o_ID_BranchEn=~(stall|freeze); o_ID_IFIDFlush=i_IF_PCSrc&o_ID_BranchEn.
- Redirect while stalled/frozen is ignored; branch re-resolves after operands arrive.
- Watchdog: fcnt counts consecutive freeze cycles, clears when freeze=0; fcnt reaching TIMEOUT sets o_MemTimeout, which stays set until reset. fcnt saturates.
- o_StallCount +1 each cycle o_EX_Bubble=1; o_FlushCount +1 each cycle o_ID_IFIDFlush=1; both saturate at all-ones.
- Register-file write-then-read bypass for WB is outside this block.

## Timing
- Reset (async assert): state RUN, cnt 0, fcnt 0, counters 0, o_MemTimeout 0; outputs then o_IF_PCWrite=1, o_ID_IFIDWrite=1, o_ID_BranchEn=1, others 0 (inputs idle).
- Reset mid-STALL or mid-freeze aborts immediately; no residual stall after release.
- Hazard-to-stall latency 0 cycles (same cycle). Load-use: 1 bubble; load->branch: 2 bubbles, consecutive unless a freeze intervenes (freeze cycles inserted between, bubble count unchanged).
- Memory: ready in same cycle as access -> zero freeze cycles; ready k cycles late -> exactly k freeze cycles.
- Flush asserted in the same cycle as i_IF_PCSrc; one-cycle effect.
- Counters update on the edge after the qualifying cycle.

## Structure
- Shared pipeline package: state enum {RUN, STALL}, register-zero constant, nop instruction constant.
- Single sub-module hazard_detect: purely combinational N computation; FSM, watchdog and counters in hazard_ctrl.

## Test plan
- EX lw $8, ID add $9,$8,$1 -> one cycle: PCWrite=0, IFIDWrite=0, Bubble=1; next cycle clean; StallCount=1.
- EX lw $8, ID beq $8,$2 -> two consecutive bubble cycles (RUN->STALL->RUN), BranchEn=0 both; StallCount=2.
- EX addi $8 (non-load), ID beq $8 -> one bubble; EX write $0 with ID beq $0 -> no stall.
- ID taken branch, no hazard, i_IF_PCSrc=1 -> IFIDFlush=1 same cycle, FlushCount=1; PCSrc during stall -> no flush.
- Load-branch hazard with i_MEM_Access=1, ready 3 cycles late inside STALL -> 3 freeze cycles (Bubble=0), then remaining bubble, total bubbles 2.
- TIMEOUT=4, i_MEM_Ready held 0 -> o_MemTimeout=1 after 4 freeze cycles, stays 1 after ready; nrst low mid-freeze clears all.
